// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// Iterative radix-2 multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, signs fixed at the end.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, aux_q, aux_d, opd_q, opd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic is_div_q, is_div_d, negq_q, negq_d, negr_q, negr_d;
    logic dz_q, dz_d, done_q, done_d, dzo_q, dzo_d;

    logic sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, madd, q_fix, r_fix;
    logic [WIDTH:0] msum, trial, diff;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign sgn   = ~op[0];
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // acc holds the product high half / partial remainder,
    // aux the multiplier bits / dividend bits becoming the quotient
    assign madd  = aux_q[0] ? opd_q : '0;
    assign msum  = {1'b0, acc_q} + {1'b0, madd};
    assign trial = {acc_q, aux_q[WIDTH-1]};
    assign diff  = trial - {1'b0, opd_q};

    assign prod     = {acc_q, aux_q};
    assign prod_fix = negq_q ? -prod : prod;
    assign q_fix    = negq_q ? -aux_q : aux_q;
    assign r_fix    = negr_q ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        aux_d    = aux_q;
        opd_d    = opd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        dzo_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    negq_d   = a_neg ^ b_neg;
                    negr_d   = a_neg;
                    dz_d     = op[1] && (b == '0);
                    cnt_d    = CW'(WIDTH);
                    acc_d    = '0;
                    aux_d    = op[1] ? a_mag : b_mag;
                    opd_d    = op[1] ? b_mag : a_mag;
                    state_d  = (op[1] && (b == '0)) ? FIN : RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    if (!diff[WIDTH]) begin
                        acc_d = diff[WIDTH-1:0];
                        aux_d = {aux_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = trial[WIDTH-1:0];
                        aux_d = {aux_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = msum[WIDTH:1];
                    aux_d = {msum[0], aux_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(1)) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dzo_d   = dz_q;
                if (!dz_q) begin
                    hi_d = is_div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = is_div_q ? q_fix : prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            aux_q    <= '0;
            opd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            dzo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            aux_q    <= aux_d;
            opd_q    <= opd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
            dzo_q    <= dzo_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = dzo_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// Bench for muldiv_unit: latency/arithmetic model plus directed vectors.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Arithmetic reference using plain 64-bit integer operators
    function automatic void model(input logic [1:0] o,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l,
                                  output bit dz);
        logic signed [63:0] sx, sy, sr64;
        logic [63:0] ux, uy, ur64;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        h = '0;
        l = '0;
        dz = 1'b0;
        case (o)
            2'd0: begin sr64 = sx * sy; h = sr64[63:32]; l = sr64[31:0]; end
            2'd1: begin ur64 = ux * uy; h = ur64[63:32]; l = ur64[31:0]; end
            2'd2: begin
                if (y == 0) dz = 1'b1;
                else begin
                    sr64 = sx / sy; l = sr64[31:0];
                    sr64 = sx % sy; h = sr64[31:0];
                end
            end
            default: begin
                if (y == 0) dz = 1'b1;
                else begin
                    ur64 = ux / uy; l = ur64[31:0];
                    ur64 = ux % uy; h = ur64[31:0];
                end
            end
        endcase
    endfunction

    // Transaction-level model: an accepted op completes after a fixed latency
    bit          m_busy = 0, m_done = 0, m_dz = 0, m_acc = 0, p_dz = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_left = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_done = 0; m_dz = 0;
            m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_acc = start && !m_busy;
            m_done = 0;
            m_dz = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    m_dz = p_dz;
                    if (!p_dz) begin m_hi = p_hi; m_lo = p_lo; end
                end
            end
            if (m_acc) begin
                model(op, a, b, p_hi, p_lo, p_dz);
                m_left = p_dz ? 1 : W + 1;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, m_done);
            check("cyc_div_zero", div_zero, m_dz);
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    task automatic go(input logic [1:0] o, input logic [31:0] x,
                      input logic [31:0] y);
        @(posedge clk); #1;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int lat, output bit busy_gap);
        lat = -1;
        busy_gap = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            if (!busy) busy_gap = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_check(input string name, input logic [1:0] o,
                             input logic [31:0] x, input logic [31:0] y,
                             input int exp_lat, input logic [31:0] eh,
                             input logic [31:0] el, input bit edz);
        int lat;
        bit gap;
        go(o, x, y);
        wait_done(lat, gap);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        check({name, "_dz"}, div_zero, edz);
        check({name, "_busy_done"}, busy, 0);
        check({name, "_busy_gap"}, gap, 0);
    endtask

    initial begin
        logic [31:0] th, tl;
        bit tdz, saw, gap;
        int lat;

        model(2'd0, 32'hFFFFFFFD, 32'd7, th, tl, tdz);
        check("model_mult", {th, tl}, 64'hFFFFFFFF_FFFFFFEB);
        model(2'd2, 32'hFFFFFFF9, 32'd2, th, tl, tdz);
        check("model_div", {th, tl}, 64'hFFFFFFFF_FFFFFFFD);
        model(2'd2, 32'h80000000, 32'hFFFFFFFF, th, tl, tdz);
        check("model_div_ovf", {th, tl}, 64'h00000000_80000000);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        chk_en = 1'b1;
        #2 reset = 1'b1;

        run_check("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd7, 33,
                  32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_check("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 33,
                  32'hFFFFFFFE, 32'h00000001, 0);
        run_check("mult_m1", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33,
                  32'h00000000, 32'h00000001, 0);
        run_check("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2, 33,
                  32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_check("divu", 2'd3, 32'hFFFFFFF9, 32'd2, 33,
                  32'h00000001, 32'h7FFFFFFC, 0);
        run_check("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 33,
                  32'h00000000, 32'h80000000, 0);
        run_check("divu_setup", 2'd3, 32'h56781234, 32'h00010000, 33,
                  32'h00001234, 32'h00005678, 0);
        run_check("divu_zero", 2'd3, 32'd5, 32'd0, 1,
                  32'h00001234, 32'h00005678, 1);
        @(posedge clk); #1;
        check("dz_pulse_end_done", done, 0);
        check("dz_pulse_end_dz", div_zero, 0);

        // New operands pulsed mid-operation must not disturb the result
        go(2'd0, 32'd5, 32'd9);
        repeat (5) @(posedge clk);
        #1;
        op = 2'd3; a = 32'd77; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, gap);
        check("ign_lat", lat, 33);
        check("ign_lo", lo, 32'd45);
        check("ign_hi", hi, 0);

        // Start held high across the done cycle gives back-to-back ops
        @(posedge clk); #1;
        op = 2'd1; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        op = 2'd2; a = 32'd100; b = 32'd7;
        wait_done(lat, gap);
        check("b2b1_lat", lat, 33);
        check("b2b1_lo", lo, 32'd3000);
        check("b2b1_hi", hi, 0);
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
        wait_done(lat, gap);
        check("b2b2_lat", lat, 33);
        check("b2b2_lo", lo, 32'd14);
        check("b2b2_hi", hi, 32'd2);

        // Asynchronous reset mid-multiply
        go(2'd0, 32'h12345678, 32'h9ABCDEF0);
        repeat (10) @(posedge clk);
        #4 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_done", done, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        check("arst_no_done", saw, 0);
        run_check("post_rst", 2'd0, 32'd6, 32'd7, 33,
                  32'h00000000, 32'h0000002A, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
